// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: two requester ports plus the data-memory pins.
// slave = arbiter view, master = requesters/memory view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              req0, req1;
  logic              we0, we1;
  logic [MASK_W-1:0] mask0, mask1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              stall0;

  logic              mem_cs;
  logic              mem_wr;
  logic [MASK_W-1:0] mem_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, mask0, mask1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
    output mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, mask0, mask1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, stall0,
    input  mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port.
// Define DMEM_ARB_RR_EN for round-robin; default is fixed priority with starvation counter.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  logic gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
  // Index that wins the next contended cycle; points away from the last winner.
  logic rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr_q <= 1'b0;
    else if (gnt0 || gnt1)
      rr_ptr_q <= gnt0;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end
`else
  typedef enum logic {COUNT, FORCE} wait_state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wait_state_e state_q, state_d;
  logic [3:0]  wait1_q, wait1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COUNT;
      wait1_q <= '0;
    end else begin
      state_q <= state_d;
      wait1_q <= wait1_d;
    end
  end

  // FORCE always returns to COUNT: req1 either drops or is granted there.
  always_comb begin
    state_d = COUNT;
    wait1_d = '0;
    case (state_q)
      COUNT: begin
        if (bus.req1 && !gnt1) begin
          wait1_d = wait1_q + 4'd1;
          if (wait1_d == MAX_WAIT_C)
            state_d = FORCE;
        end
      end
      FORCE:   state_d = COUNT;
      default: state_d = COUNT;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      gnt1 = bus.req1 && (!bus.req0 || state_q == FORCE);
      gnt0 = bus.req0 && !gnt1;
    end
  end
`endif

  logic              sel_we;
  logic [MASK_W-1:0] sel_mask;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_we    = bus.we0;
    sel_mask  = bus.mask0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (gnt1) begin
      sel_we    = bus.we1;
      sel_mask  = bus.mask1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  logic rd_issue_q, issue_owner_q;
  logic rd_pend_q, owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_cs    <= 1'b1;
      bus.mem_wr    <= 1'b1;
      bus.mem_mask  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rd_issue_q    <= 1'b0;
      issue_owner_q <= 1'b0;
    end else if (gnt0 || gnt1) begin
      bus.mem_cs    <= 1'b0;
      bus.mem_wr    <= ~sel_we;
      bus.mem_mask  <= sel_mask;
      bus.mem_addr  <= sel_addr;
      bus.mem_wdata <= sel_wdata;
      rd_issue_q    <= ~sel_we;
      issue_owner_q <= gnt1;
    end else begin
      bus.mem_cs    <= 1'b1;
      bus.mem_wr    <= 1'b1;
      bus.mem_mask  <= '0;
      rd_issue_q    <= 1'b0;
    end
  end

  // Second stage lines rd_pend/owner up with the cycle mem_rdata is valid (issue + 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue_q;
      owner_q   <= issue_owner_q;
    end
  end

  logic rv0, rv1;

  assign rv0         = rd_pend_q && !owner_q;
  assign rv1         = rd_pend_q && owner_q;
  assign bus.rvalid0 = rv0;
  assign bus.rvalid1 = rv1;
  assign bus.rdata0  = rv0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = rv1 ? bus.mem_rdata : '0;
  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.stall0  = bus.req0 && !gnt0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed steps plus random traffic
// against a queue-based reference model and a byte-masked memory.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  dmem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // Physical memory behind the port: one-cycle read latency, byte-masked writes.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (!ifc.mem_cs) begin
      if (!ifc.mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (ifc.mem_mask[b]) mem[ifc.mem_addr[11:2]][b*8 +: 8] <= ifc.mem_wdata[b*8 +: 8];
      end else begin
        ifc.mem_rdata <= mem[ifc.mem_addr[11:2]];
      end
    end
  end

  typedef struct {
    int unsigned due;
    bit          owner;
    logic [31:0] data;
  } rsp_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem [0:1023];
  int unsigned refused1 = 0;
  bit          turn = 1'b0;
  logic        exp_cs, exp_wr;
  logic [3:0]  exp_mask;
  logic [31:0] exp_addr, exp_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    refused1  = 0;
    turn      = 1'b0;
    exp_cs    = 1'b1;
    exp_wr    = 1'b1;
    exp_mask  = 4'h0;
    exp_addr  = 32'h0;
    exp_wdata = 32'h0;
  endtask

  // Called at posedge+1; asserts reset, checks reset outputs, releases after n edges.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_cs",    32'(ifc.mem_cs), 32'h1);
    chk("rst_mem_wr",    32'(ifc.mem_wr), 32'h1);
    chk("rst_mem_mask",  32'(ifc.mem_mask), 32'h0);
    chk("rst_mem_addr",  ifc.mem_addr, 32'h0);
    chk("rst_mem_wdata", ifc.mem_wdata, 32'h0);
    chk("rst_gnt0",      32'(ifc.gnt0), 32'h0);
    chk("rst_gnt1",      32'(ifc.gnt1), 32'h0);
    chk("rst_rvalid0",   32'(ifc.rvalid0), 32'h0);
    chk("rst_rvalid1",   32'(ifc.rvalid1), 32'h0);
    chk("rst_rdata0",    ifc.rdata0, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check every output at negedge against the model, then advance.
  task automatic step(output bit g0, output bit g1, output bit og1);
    bit          r0, r1, e_rv0, e_rv1, w;
    logic [31:0] e_rd0, e_rd1, a, d;
    logic [3:0]  m;
    rsp_t        r;
    @(negedge clk);
    r0 = ifc.req0;
    r1 = ifc.req1;
`ifdef DMEM_ARB_RR_EN
    if (r0 && r1) begin
      g0 = (turn == 1'b0);
      g1 = (turn == 1'b1);
    end else begin
      g0 = r0;
      g1 = r1;
    end
`else
    g1 = r1 && (!r0 || refused1 >= MAX_WAIT);
    g0 = r0 && !g1;
`endif
    og1 = ifc.gnt1;
    chk("gnt0",      32'(ifc.gnt0), 32'(g0));
    chk("gnt1",      32'(ifc.gnt1), 32'(g1));
    chk("stall0",    32'(ifc.stall0), 32'(r0 && !g0));
    chk("mem_cs",    32'(ifc.mem_cs), 32'(exp_cs));
    chk("mem_wr",    32'(ifc.mem_wr), 32'(exp_wr));
    chk("mem_mask",  32'(ifc.mem_mask), 32'(exp_mask));
    chk("mem_addr",  ifc.mem_addr, exp_addr);
    chk("mem_wdata", ifc.mem_wdata, exp_wdata);
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
    if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.owner) begin e_rv1 = 1'b1; e_rd1 = r.data; end
      else         begin e_rv0 = 1'b1; e_rd0 = r.data; end
    end
    chk("rvalid0", 32'(ifc.rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(ifc.rvalid1), 32'(e_rv1));
    chk("rdata0",  ifc.rdata0, e_rd0);
    chk("rdata1",  ifc.rdata1, e_rd1);

    if (g0 || g1) begin
      w = g1 ? ifc.we1 : ifc.we0;
      m = g1 ? ifc.mask1 : ifc.mask0;
      a = g1 ? ifc.addr1 : ifc.addr0;
      d = g1 ? ifc.wdata1 : ifc.wdata0;
      exp_cs = 1'b0; exp_wr = ~w; exp_mask = m; exp_addr = a; exp_wdata = d;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_mem[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        rsp_q.push_back('{due: cyc + 2, owner: g1, data: ref_mem[a[11:2]]});
      end
      turn = g0;
    end else begin
      exp_cs = 1'b1; exp_wr = 1'b1; exp_mask = 4'h0;
    end
    if (r1 && !g1) refused1 = (refused1 < MAX_WAIT) ? refused1 + 1 : refused1;
    else           refused1 = 0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set0(input bit rq, input bit we, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    ifc.req0 = rq; ifc.we0 = we; ifc.mask0 = m; ifc.addr0 = a; ifc.wdata0 = d;
  endtask

  task automatic set1(input bit rq, input bit we, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    ifc.req1 = rq; ifc.we1 = we; ifc.mask1 = m; ifc.addr1 = a; ifc.wdata1 = d;
  endtask

  bit g0, g1, og1;

  initial begin
    model_reset();
    set0(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    do_reset(3);

    // First cycle out of reset: store 0xDEADBEEF, then lone load from 0x100.
    step(g0, g1, og1);
    chk("first_gnt0", 32'(g0), 32'h1);
    set0(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    step(g0, g1, og1);
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step(g0, g1, og1);

    // Requester 1 partial store.
    set1(1'b1, 1'b1, 4'b1100, 32'h104, 32'hABCD0000);
    step(g0, g1, og1);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step(g0, g1, og1);

    // Continuous contention on the same address.
    do_reset(1);
    set0(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    set1(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step(g0, g1, og1);
`ifdef DMEM_ARB_RR_EN
      chk("pattern_gnt1", 32'(og1), 32'(i % 2 == 1));
`else
      chk("pattern_gnt1", 32'(og1), 32'(i % (MAX_WAIT + 1) == MAX_WAIT));
`endif
    end
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step(g0, g1, og1);

    // Back-to-back loads from both requesters.
    set0(1'b1, 1'b1, 4'hF, 32'h10, 32'h11);
    step(g0, g1, og1);
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set1(1'b1, 1'b1, 4'hF, 32'h20, 32'h22);
    step(g0, g1, og1);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(g0, g1, og1);
    set0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step(g0, g1, og1);
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set1(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    step(g0, g1, og1);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step(g0, g1, og1);

    // Reset while a load is in flight: no response after release.
    set0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step(g0, g1, og1);
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset(2);
    repeat (4) step(g0, g1, og1);

    // Fill a 16-word region, then random traffic over it.
    for (int i = 0; i < 16; i++) begin
      set1(1'b1, 1'b1, 4'hF, 32'h200 + 32'(i) * 4, $urandom);
      step(g0, g1, og1);
    end
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(g0, g1, og1);
    for (int i = 0; i < 400; i++) begin
      if (!ifc.req0 || g0)
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
             32'h200 + 32'($urandom_range(0, 15)) * 4, $urandom);
      if (!ifc.req1 || g1)
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
             32'h200 + 32'($urandom_range(0, 15)) * 4, $urandom);
      step(g0, g1, og1);
    end
    set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step(g0, g1, og1);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port driven by the load/store unit. It shares the port between requester 0 (core LSU, memory-side signals already formed: `cs`/`wr`/`mask`/`addr`/`data_wr`) and requester 1 (debug/DMA master). It registers the winning request onto the memory pins and routes the one-cycle-late read data back to the owning requester. It sits between the LSU outputs and the data memory; a core stall is derived from `gnt0`.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; mask width is `DATA_W/8`.
- `MAX_WAIT`, 4: cycles requester 1 may be refused before it is forced to win. Fixed-priority mode only; legal range 1..15.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0` / `req1` in 1: request valid, per requester.
- `we0` / `we1` in 1: 1 = store, 0 = load.
- `mask0` / `mask1` in 4: byte enables for a store.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: store data, already lane-aligned.
- `gnt0` / `gnt1` in/out — output, 1: one-cycle pulse, request accepted this cycle.
- `rvalid0` / `rvalid1` out 1: one-cycle pulse, load data on `rdata0` / `rdata1`.
- `rdata0` / `rdata1` out DATA_W: load data; zero when the matching `rvalid` is low.
- `stall0` out 1: `req0 & ~gnt0`.
- `mem_cs` out 1: memory chip select, active-low.
- `mem_wr` out 1: 0 = write, 1 = read.
- `mem_mask` out 4: byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after a read issue.

## Operation
- Arbitration is evaluated every cycle in which any `req` is high. Exactly one `gnt` pulses for the winner; the loser is not granted.
- Requesters hold `req`, `we`, `mask`, `addr` and `wdata` stable until `gnt`. After `gnt` they may drop `req` or present a new request in the next cycle.
- Issue register: on a grant, the winner's fields are captured into the `mem_*` registers, with `mem_cs`=0 and `mem_wr`=~we. Cycles without a grant load the idle value: `mem_cs`=1, `mem_wr`=1, `mem_mask`=0. Address and data hold their last value.
- Loads: the issue register also captures `owner` (granted index) and `rd_pend`=1. While `rd_pend` is set, `mem_rdata` is forwarded combinationally to `rdata[owner]` and `rvalid[owner]` is pulsed.
- Stores produce no `rvalid`.
- Fixed-priority mode (default):
  - Requester 0 wins unless the starvation counter `wait1` has reached `MAX_WAIT`.
  - `wait1` increments, saturating, each cycle `req1` is high and not granted.
  - `wait1` clears on `gnt1` or when `req1` is low.
  - When `wait1 == MAX_WAIT` and `req1` is high, requester 1 wins even if `req0` is high.
- States of `wait1`:
  - COUNT (`wait1 < MAX_WAIT`): go to FORCE when the count reaches `MAX_WAIT`.
  - FORCE: go to COUNT (0) on `gnt1` or when `req1` drops.

## Timing
- Grant is combinational in cycle N.
- `mem_cs` is low in cycle N+1.
- Load: `mem_rdata` is valid and `rvalid` pulses in cycle N+2. Load-to-use latency is 2 cycles.
- Throughput is one access per cycle, and grants may be back-to-back. Read responses pipeline in issue order; at most two accesses are in flight.
- Reset values (asynchronous, immediate on `rst_n`=0):
  - memory side: `mem_cs`=1, `mem_wr`=1, `mem_mask`=0, `mem_addr`=0, `mem_wdata`=0;
  - internal state: `rd_pend`=0, `owner`=0, `wait1`=0, round-robin pointer=0;
  - outputs: all `gnt`=0, `rvalid`=0, `rdata`=0.
- Reset mid-load: the pending response is discarded and no `rvalid` follows release.
- Simultaneous requests with the same address from both requesters: only the winner issues; no merging.
- `req` asserted during reset is ignored. First grant is possible in the first cycle with `rst_n`=1.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - round-robin arbitration; the last-granted pointer flips to the other requester after each grant;
  - on contention, the requester not granted last wins; a lone requester always wins;
  - `wait1` and `MAX_WAIT` logic are compiled out.
- `DMEM_ARB_RR_EN` undefined: fixed priority with the starvation counter described above.

## Test plan
- Reset: hold `rst_n`=0 with `req0`=1. Required: `mem_cs`=1, `gnt0`=0, `rvalid0`=0. Release; the first cycle gives `gnt0`=1.
- Lone load: `req0`=1, `we0`=0, `addr0`=0x100, memory returns 0xDEADBEEF. Required: `gnt0` in N, `mem_cs`=0 / `mem_wr`=1 / `mem_addr`=0x100 in N+1, `rvalid0`=1 with `rdata0`=0xDEADBEEF in N+2, `rvalid1`=0.
- Store: `req1`=1, `we1`=1, `mask1`=4'b1100, `wdata1`=0xABCD0000. Required: in N+1, `mem_cs`=0, `mem_wr`=0, `mem_mask`=4'b1100; no `rvalid`.
- Starvation (fixed priority, `MAX_WAIT`=4): `req0` and `req1` held high continuously. Required: four `gnt0` pulses, then one `gnt1`, then repeat.
- Round-robin (`DMEM_ARB_RR_EN`): both requesting continuously. Required: grants alternate 0,1,0,1 starting with 0 after reset.
- Back-to-back loads: 0 then 1, to addresses 0x10 and 0x20, data 0x11 and 0x22. Required: `rvalid0`/0x11 and `rvalid1`/0x22 in consecutive cycles. Assert reset between them: no `rvalid` after release.
